snake_step_engine: RTL

Game-logic controller for the 15x15 snake playfield, sitting directly upstream of the world memory (2-bit cells: 00 empty, 01 food, 10 snake, 11 unused). On each game tick it computes the new head cell, reads the target cell, detects wall and self collisions and food, then writes the head, erases the tail, and places new food when needed. It owns the snake body as a circular position buffer and is the only master on the memory's address, data and read-enable lines.

---
 rtl/snake_step_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/snake_step_engine.sv
// Snake game-step controller: moves the head, erases the tail, places food.
// Sole master of the world memory's address, write-data and read-enable lines.
module snake_step_engine #(
    parameter int         GRID      = 15,
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] dir,
    output logic [4:0] mem_x,
    output logic [4:0] mem_y,
    output logic       mem_read_en,
    output logic [1:0] mem_wdata,
    input  logic [1:0] mem_rdata,
    output logic [5:0] length,
    output logic [7:0] score,
    output logic       busy,
    output logic       game_over
);
    localparam int         PW        = $clog2(MAX_LEN);
    localparam logic [4:0] GRID_L    = 5'(GRID);
    localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_CALC, S_READ, S_WHEAD, S_ETAIL, S_FPICK, S_FREAD, S_FWRITE, S_DEAD
    } state_t;

    state_t         state, state_d;
    logic [7:0]     body [MAX_LEN];
    logic [PW-1:0]  head_ptr, tail_ptr, head_nxt;
    logic [7:0]     head_xy, tail_xy, lfsr;
    logic [1:0]     cur_dir;
    logic [4:0]     nx, ny, calc_x, calc_y, hx, hy;
    logic [3:0]     fx, fy;
    logic [7:0]     fcnt;
    logic           grow, wall;

    assign head_xy  = body[head_ptr];
    assign head_nxt = head_ptr + PW'(1);
    assign hx       = {1'b0, head_xy[7:4]};
    assign hy       = {1'b0, head_xy[3:0]};
    assign busy     = (state != S_IDLE) && (state != S_DEAD);

    always_comb begin
        calc_x = hx;
        calc_y = hy;
        case (cur_dir)
            2'b00: calc_x = hx + 5'd1;
            2'b01: calc_y = hy + 5'd1;
            2'b10: calc_x = hx - 5'd1;
            default: calc_y = hy - 5'd1;
        endcase
        wall = (calc_x == 5'd0) || (calc_x > GRID_L) || (calc_y == 5'd0) || (calc_y > GRID_L);
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (tick) state_d = S_CALC;
            S_CALC:   state_d = wall ? S_DEAD : S_READ;
            S_READ:   state_d = (mem_rdata == 2'b10) ? S_DEAD : S_WHEAD;
            S_WHEAD:  state_d = (grow && length < MAX_LEN_L) ? S_FPICK : S_ETAIL;
            S_ETAIL:  state_d = grow ? S_FPICK : S_IDLE;
            S_FPICK: begin
                if (fcnt == 8'hFF)
                    state_d = S_IDLE;
                else if (lfsr[3:0] != 4'd0 && lfsr[7:4] != 4'd0)
                    state_d = S_FREAD;
            end
            S_FREAD:  state_d = (mem_rdata == 2'b00) ? S_FWRITE : S_FPICK;
            S_FWRITE: state_d = S_IDLE;
            S_DEAD:   state_d = S_DEAD;
            default:  state_d = S_IDLE;
        endcase
    end

    // Writes index the memory with x-1; reads use x directly.
    always_comb begin
        mem_x       = 5'd0;
        mem_y       = 5'd0;
        mem_wdata   = 2'b00;
        mem_read_en = 1'b1;
        case (state)
            S_READ:   begin mem_x = nx; mem_y = ny; end
            S_WHEAD:  begin mem_x = nx - 5'd1; mem_y = ny; mem_wdata = 2'b10; mem_read_en = 1'b0; end
            S_ETAIL: begin
                mem_x       = {1'b0, tail_xy[7:4]} - 5'd1;
                mem_y       = {1'b0, tail_xy[3:0]};
                mem_read_en = 1'b0;
            end
            S_FREAD:  begin mem_x = {1'b0, fx}; mem_y = {1'b0, fy}; end
            S_FWRITE: begin mem_x = {1'b0, fx} - 5'd1; mem_y = {1'b0, fy}; mem_wdata = 2'b01; mem_read_en = 1'b0; end
            default:  ;
        endcase
        if (rst) mem_read_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                body[i] <= (i == 0) ? 8'h11 : (i == 1) ? 8'h21 : (i == 2) ? 8'h31 : 8'h00;
            end
            tail_ptr  <= '0;
            head_ptr  <= PW'(2);
            length    <= 6'd3;
            cur_dir   <= 2'b00;
            score     <= 8'd0;
            game_over <= 1'b0;
            lfsr      <= LFSR_SEED;
            nx        <= 5'd0;
            ny        <= 5'd0;
            grow      <= 1'b0;
            tail_xy   <= 8'h00;
            fx        <= 4'd0;
            fy        <= 4'd0;
            fcnt      <= 8'd0;
        end else begin
            state <= state_d;
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            case (state)
                S_IDLE: if (tick && ((dir ^ 2'b10) != cur_dir)) cur_dir <= dir;
                S_CALC: begin nx <= calc_x; ny <= calc_y; end
                S_READ: grow <= (mem_rdata == 2'b01);
                S_WHEAD: begin
                    // Capture the tail now: a full buffer's push lands on the tail slot.
                    tail_xy        <= body[tail_ptr];
                    body[head_nxt] <= {nx[3:0], ny[3:0]};
                    head_ptr       <= head_nxt;
                    fcnt           <= 8'd0;
                    if (grow && score != 8'hFF) score <= score + 8'd1;
                    if (grow && length < MAX_LEN_L) length <= length + 6'd1;
                end
                S_ETAIL: begin
                    tail_ptr <= tail_ptr + PW'(1);
                    fcnt     <= 8'd0;
                end
                S_FPICK: begin
                    fx <= lfsr[3:0];
                    fy <= lfsr[7:4];
                    if (fcnt != 8'hFF) fcnt <= fcnt + 8'd1;
                end
                S_DEAD: game_over <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
